// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture: PDM clock generator and stereo data capture for a MEMS
// microphone array. Each data line carries a left mic (sampled at the end of
// the pdm_clk high phase) and a right mic (sampled at the end of the low
// phase). One aligned bit per channel is presented with a single-cycle strobe
// per PDM period. Start-up discards a settling interval; stopping always ends
// on a completed low phase so the mics never see a runt clock pulse.
//
// Optional build macro PDM_LFSR_EN: adds the test_mode input, which replaces
// captured data with a 16-bit Fibonacci LFSR pattern (taps 16,14,13,11,
// seed 16'hACE1) advanced once per valid strobe.
//
// Handshake: bits_valid is a one-cycle strobe with no ready; bits_out is
// stable from one strobe until the next and every strobe must be consumed.
module pdm_mic_capture #(
    parameter int NUM_LINES    = 8,
    parameter int CLK_DIV      = 8,
    parameter int WAKE_PERIODS = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
`ifdef PDM_LFSR_EN
    input  logic                   test_mode,
`endif
    input  logic [NUM_LINES-1:0]   pdm_data,
    output logic                   pdm_clk,
    output logic [2*NUM_LINES-1:0] bits_out,
    output logic                   bits_valid,
    output logic                   running,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAKE = 2'd1,
        S_RUN  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] WAKE_LAST = 16'(WAKE_PERIODS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             div_cnt;
    logic [15:0]            wake_cnt;
    logic [NUM_LINES-1:0]   l_hold;
    logic                   wrap;
    logic                   rise_wrap;
    logic                   fall_wrap;
    logic                   clk_toggle;
    logic                   cap_en;
    logic                   strobe;
    logic                   run_d;
    logic [2*NUM_LINES-1:0] cap_bits;

    // A wrap is the last system cycle of a PDM half-period; which edge it
    // precedes depends on the current pdm_clk level.
    assign wrap      = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign rise_wrap = wrap && !pdm_clk;
    assign fall_wrap = wrap && pdm_clk;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; dropping enable always goes through STOP so the
    // clock ends on a full low phase, and STOP ignores enable until done.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (enable) state_next = S_WAKE;
            S_WAKE: begin
                if (!enable)
                    state_next = S_STOP;
                else if (rise_wrap && (wake_cnt == WAKE_LAST))
                    state_next = S_RUN;
            end
            S_RUN:  if (!enable) state_next = S_STOP;
            S_STOP: if (rise_wrap) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: STOP suppresses the final rising edge and its capture;
    // strobes are produced only in RUN.
    always_comb begin
        clk_toggle = wrap && !((state == S_STOP) && !pdm_clk);
        cap_en     = rise_wrap && (state != S_STOP);
        strobe     = rise_wrap && (state == S_RUN);
        run_d      = (state_next == S_WAKE) || (state_next == S_RUN);
    end

`ifdef PDM_LFSR_EN
    logic [15:0] lfsr;

    // Test pattern generator: reseeded whenever idle, advanced per strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= 16'hACE1;
        else if (state == S_IDLE)
            lfsr <= 16'hACE1;
        else if (strobe)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`endif

    // Channel interleave: even channel = left (held), odd = right (live).
    always_comb begin
        cap_bits = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            cap_bits[2*k]   = l_hold[k];
            cap_bits[2*k+1] = pdm_data[k];
        end
`ifdef PDM_LFSR_EN
        if (test_mode) begin
            for (int c = 0; c < 2*NUM_LINES; c++)
                cap_bits[c] = lfsr[c % 16];
        end
`endif
    end

    // Divider and registered PDM clock; both parked low in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= 8'd0;
            pdm_clk <= 1'b0;
        end else if (state == S_IDLE) begin
            div_cnt <= 8'd0;
            pdm_clk <= 1'b0;
        end else if (wrap) begin
            div_cnt <= 8'd0;
            if (clk_toggle) pdm_clk <= ~pdm_clk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Wake counter: cleared while idle, counts rising edges during WAKE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wake_cnt <= 16'd0;
        else if (state == S_IDLE)
            wake_cnt <= 16'd0;
        else if ((state == S_WAKE) && rise_wrap)
            wake_cnt <= wake_cnt + 16'd1;
    end

    // Capture path: left bits held at the falling wrap, full word and
    // strobe registered at the rising wrap; running follows the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_hold     <= '0;
            bits_out   <= '0;
            bits_valid <= 1'b0;
            running    <= 1'b0;
        end else begin
            bits_valid <= strobe;
            running    <= run_d;
            if (fall_wrap) l_hold   <= pdm_data;
            if (cap_en)    bits_out <= cap_bits;
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture (NUM_LINES=2, CLK_DIV=4, WAKE_PERIODS=4):
// closed-form timeline model with random data, a vector table for the
// channel interleave, and hand-written stop/restart/reset sequences.
module tb_pdm_mic_capture;

    localparam int NL   = 2;
    localparam int CD   = 4;
    localparam int WP   = 4;
    localparam int NCH  = 2 * NL;
    localparam int MAXN = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic [NL-1:0]  pdm_data = '0;
`ifdef PDM_LFSR_EN
    logic           test_mode = 1'b0;
`endif
    logic           pdm_clk;
    logic [NCH-1:0] bits_out;
    logic           bits_valid;
    logic           running;
    logic [1:0]     state_dbg;

    int             checks = 0;
    int             errors = 0;
    logic           phase_drv = 1'b0;
    logic [NL-1:0]  hi_d = '0;
    logic [NL-1:0]  lo_d = '0;
    logic [NCH-1:0] exp_q[$];

    typedef struct {
        logic [NL-1:0]  hi;
        logic [NL-1:0]  lo;
        logic [NCH-1:0] exp_bits;
    } vec_t;

    vec_t vecs[6];

    pdm_mic_capture #(
        .NUM_LINES(NL),
        .CLK_DIV(CD),
        .WAKE_PERIODS(WP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
`ifdef PDM_LFSR_EN
        .test_mode(test_mode),
`endif
        .pdm_data(pdm_data),
        .pdm_clk(pdm_clk),
        .bits_out(bits_out),
        .bits_valid(bits_valid),
        .running(running),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (phase_drv) pdm_data = pdm_clk ? hi_d : lo_d;
    endtask

    task automatic wait_strobe(input int budget, input string name);
        int got;
        got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            step();
            if (bits_valid) got = 1;
        end
        check({name, "_strobe_seen"}, 32'(got), 32'd1);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Timeline model from WAKE entry (n=0): pdm_clk is high in half-periods
    // of odd index, rises at n = CD + 2*CD*(r-1), strobes from rise WP+1 on.
    // Data sampled at edge m is what was driven after sample point m-1.
    task automatic run_model(input int ncyc, input string tag);
        logic [NL-1:0]  d [MAXN];
        logic [NCH-1:0] eb;
        logic [NCH-1:0] got_bits;
        logic           ev;
        logic           ec;
        int             found;
        int             ridx;
        int             rr;
        found = 0;
        exp_q.delete();
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (running) found = 1;
        end
        check({tag, "_wake_entry"}, 32'(found), 32'd1);
        for (int n = 0; n < ncyc; n++) begin
            ec = ((n / CD) % 2) == 1;
            ev = 1'b0;
            eb = '0;
            if (n >= CD) begin
                ridx = (n - CD) / (2 * CD) + 1;
                rr   = CD + (ridx - 1) * 2 * CD;
                for (int k = 0; k < NL; k++) begin
                    eb[2*k]   = (ridx == 1) ? 1'b0 : d[rr-CD-1][k];
                    eb[2*k+1] = d[rr-1][k];
                end
                if ((rr == n) && (ridx > WP)) begin
                    ev = 1'b1;
                    exp_q.push_back(eb);
                end
            end
            check($sformatf("%s_pdm_clk_n%0d", tag, n), 32'(pdm_clk), 32'(ec));
            check($sformatf("%s_valid_n%0d", tag, n), 32'(bits_valid), 32'(ev));
            check($sformatf("%s_bits_n%0d", tag, n), 32'(bits_out), 32'(eb));
            check($sformatf("%s_running_n%0d", tag, n), 32'(running), 32'd1);
            if (bits_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_unexpected_strobe_n%0d", tag, n), 32'd1, 32'd0);
                end else begin
                    got_bits = exp_q.pop_front();
                    check($sformatf("%s_sb_bits_n%0d", tag, n), 32'(bits_out), 32'(got_bits));
                end
            end
            d[n] = NL'($urandom_range(0, (1 << NL) - 1));
            pdm_data = d[n];
            step();
        end
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int hi_cnt;
        int lo_cnt;
        int idle_len;
        int any_valid;
        int n;
        int rises;
        int first_rise;
        logic prev;
        logic [15:0] lv;

        vecs[0] = '{hi: 2'b01, lo: 2'b10, exp_bits: 4'b1001};
        vecs[1] = '{hi: 2'b11, lo: 2'b00, exp_bits: 4'b0101};
        vecs[2] = '{hi: 2'b00, lo: 2'b11, exp_bits: 4'b1010};
        vecs[3] = '{hi: 2'b10, lo: 2'b01, exp_bits: 4'b0110};
        vecs[4] = '{hi: 2'b11, lo: 2'b11, exp_bits: 4'b1111};
        vecs[5] = '{hi: 2'b00, lo: 2'b00, exp_bits: 4'b0000};

        // Reset state
        step();
        step();
        check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("rst_bits_out", 32'(bits_out), 32'd0);
        check("rst_bits_valid", 32'(bits_valid), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // Start-up timing and random capture against the timeline model
        rst = 1'b1;
        enable = 1'b1;
        run_model(100, "start");

        // Interleave vectors with phase-aligned data
        phase_drv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hi_d = vecs[i].hi;
            lo_d = vecs[i].lo;
            wait_strobe(40, $sformatf("vec%0d_a", i));
            wait_strobe(40, $sformatf("vec%0d_b", i));
            check($sformatf("vec%0d_bits", i), 32'(bits_out), 32'(vecs[i].exp_bits));
        end

        // Stop mid-high-phase: high completes, one full low, then parked
        hi_d = 2'b01;
        lo_d = 2'b10;
        wait_strobe(40, "stop_pre");
        step();
        enable = 1'b0;
        hi_cnt = 2;
        any_valid = 0;
        step();
        check("stop_entry_state", 32'(state_dbg), 32'd3);
        check("stop_entry_running", 32'(running), 32'd0);
        for (int i = 0; i < 20 && pdm_clk; i++) begin
            hi_cnt++;
            step();
            if (bits_valid) any_valid = 1;
        end
        check("stop_high_len", 32'(hi_cnt), 32'(CD));
        lo_cnt = 0;
        for (int i = 0; i < 20 && state_dbg == 2'd3; i++) begin
            if (pdm_clk) any_valid = 1;
            lo_cnt++;
            step();
            if (bits_valid) any_valid = 1;
        end
        check("stop_low_len", 32'(lo_cnt), 32'(CD));
        check("stop_end_state", 32'(state_dbg), 32'd0);
        check("stop_end_running", 32'(running), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (pdm_clk || bits_valid) any_valid = 1;
            step();
        end
        check("stop_quiet", 32'(any_valid), 32'd0);

        // Enable pulsed low then high inside STOP: full restart
        enable = 1'b1;
        wait_strobe(100, "restart_pre");
        step();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        check("restart_in_stop", 32'(state_dbg), 32'd3);
        for (int i = 0; i < 20 && state_dbg != 2'd0; i++) step();
        idle_len = 0;
        for (int i = 0; i < 10 && state_dbg == 2'd0; i++) begin
            idle_len++;
            step();
        end
        check("restart_idle_len", 32'(idle_len), 32'd1);
        check("restart_wake", 32'(state_dbg), 32'd1);
        n = 0;
        rises = 0;
        first_rise = -1;
        prev = pdm_clk;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (pdm_clk && !prev) begin
                rises++;
                if (rises == 1) first_rise = n;
            end
            prev = pdm_clk;
            if (bits_valid) break;
        end
        check("restart_first_rise", 32'(first_rise), 32'(CD));
        check("restart_rises_at_strobe", 32'(rises), 32'(WP + 1));
        check("restart_strobe_cycle", 32'(n), 32'(CD + 2 * CD * WP));

        // One-cycle reset mid-RUN, then a modelled restart
        step();
        step();
        rst = 1'b0;
        #1;
        check("midrst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("midrst_bits_out", 32'(bits_out), 32'd0);
        check("midrst_bits_valid", 32'(bits_valid), 32'd0);
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
        phase_drv = 1'b0;
        step();
        rst = 1'b1;
        run_model(80, "midrst");

`ifdef PDM_LFSR_EN
        // LFSR test pattern from a fresh start
        enable = 1'b0;
        for (int i = 0; i < 40 && state_dbg != 2'd0; i++) step();
        check("lfsr_idle", 32'(state_dbg), 32'd0);
        test_mode = 1'b1;
        enable = 1'b1;
        lv = 16'hACE1;
        wait_strobe(100, "lfsr0");
        check("lfsr_strobe0", 32'(bits_out), 32'(lv[NCH-1:0]));
        lv = lfsr_next(lv);
        wait_strobe(20, "lfsr1");
        check("lfsr_strobe1", 32'(bits_out), 32'(lv[NCH-1:0]));
        lv = lfsr_next(lv);
        wait_strobe(20, "lfsr2");
        check("lfsr_strobe2", 32'(bits_out), 32'(lv[NCH-1:0]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_mic_capture.md
Name: pdm_mic_capture

Overview:
- Front end of the microphone-array filter chain; sits directly upstream of the per-channel CIC decimators.
- Generates the PDM bit clock for the MEMS microphones and captures the shared stereo data lines: left mic on the high phase, right mic on the low phase.
- Presents one bit per channel, all channels aligned, with a single-cycle valid strobe once per PDM period.
- Handles microphone wake-up and glitch-free start/stop of the PDM clock.

Parameters:
- NUM_LINES, 8: number of PDM data lines; each line carries a left/right mic pair, giving 2*NUM_LINES channels.
- CLK_DIV, 8: system clocks per PDM half-period; legal range 2..255.
- WAKE_PERIODS, 1024: PDM periods discarded after start while the mics settle; legal range 1..65535.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: request to run the PDM clock and capture.
- pdm_data, input, NUM_LINES: mic data lines, already synchronised by pad flops outside this block.
- pdm_clk, output, 1: PDM clock to the mics; registered, 50% duty.
- bits_out, output, 2*NUM_LINES: captured bits. bits_out[2k] is the left mic of line k; bits_out[2k+1] is the right mic of line k.
- bits_valid, output, 1: one-cycle strobe once per PDM period; bits_out is stable until the next strobe.
- running, output, 1: high in WAKE and RUN.

Behaviour:
- Reset (rst low, asynchronous):
  - pdm_clk=0, bits_out=0, bits_valid=0, running=0.
  - Divider count, wake count and left holding register cleared.
  - State=IDLE.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while in WAKE, RUN or STOP.
  - At div_cnt==CLK_DIV-1, pdm_clk toggles and div_cnt returns to 0.
  - PDM period = 2*CLK_DIV clk cycles.
  - In IDLE, div_cnt is held at 0 and pdm_clk is held low.
- Capture (both points are sampled at the end of the phase, just before the opposite edge):
  - On the wrap cycle with pdm_clk==1: l_hold <= pdm_data.
  - On the wrap cycle with pdm_clk==0: bits_out <= interleave(l_hold, pdm_data). bits_valid <= 1 for one cycle, but only in RUN.
  - bits_out and bits_valid therefore update on the same clk edge on which pdm_clk rises.
  - In WAKE, bits_out still updates but bits_valid stays 0.
- State machine:
  - IDLE: if enable=1, go to WAKE next cycle and clear wake_cnt. The first pdm_clk rise occurs CLK_DIV cycles after WAKE entry.
  - WAKE: wake_cnt increments at each rising wrap. When it reaches WAKE_PERIODS, go to RUN. The first valid strobe is the (WAKE_PERIODS+1)-th rising edge.
  - RUN: if enable=0, go to STOP.
  - WAKE with enable=0: go to STOP; no valid strobes are ever produced.
  - STOP: keep clocking until the wrap at which pdm_clk would rise. At that cycle pdm_clk stays low, no strobe is produced, and the next state is IDLE. This guarantees no runt pulses.
  - STOP entered while pdm_clk=0: the low phase completes normally at full length.
  - enable re-asserted during STOP: ignored. STOP completes, IDLE lasts one cycle, then a full WAKE follows (wake count restarts).
- running is registered and reflects the state after each transition.
- Reset mid-operation: immediate return to reset values. pdm_clk may be truncated; this is allowed only under reset.
- Boundaries:
  - wake_cnt is 16 bits and never wraps, since it stops at WAKE_PERIODS.
  - div_cnt is 8 bits.
  - No back-pressure: downstream must consume every strobe.

Optional Feature:
- Macro: PDM_LFSR_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, captured data is replaced by a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that advances once per valid strobe.
  - Channel c receives LFSR bit (c mod 16), taken from the LFSR value before the advance.
  - The LFSR reseeds on reset and on IDLE.
  - Timing and strobes are unchanged.
- When undefined: no test_mode port and no LFSR logic. Captured data is always the pdm_data lines.

Test Plan:
1. NUM_LINES=2, CLK_DIV=4, WAKE_PERIODS=4. Release reset, enable=1 held. Expect:
   - pdm_clk period of 8 cycles;
   - first rise 4 cycles after WAKE entry;
   - no bits_valid for 4 rising edges;
   - first strobe on the 5th rise, then exactly every 8 cycles.
2. Drive pdm_data=2'b01 during high phases and 2'b10 during low phases -> bits_out=4'b1001 (line0 L=1, R=0; line1 L=0, R=1) on every strobe.
3. Deassert enable mid-high-phase in RUN. Expect:
   - high phase completes, full 4-cycle low phase follows;
   - pdm_clk then stays low, no further strobe;
   - running=0 and state IDLE; no pdm_clk pulse shorter than 4 cycles.
4. Pulse enable low then high within STOP -> STOP completes and a fresh WAKE follows; the first new strobe arrives 5 rises after the restart.
5. Assert rst low mid-RUN for one cycle -> all outputs 0 immediately. With enable held high, WAKE restarts after release.
6. With PDM_LFSR_EN defined, test_mode=1 -> the first RUN strobe has bits_out=4'b0001 (bit[3:0] of 16'hACE1). The second strobe equals bits[3:0] of the advanced LFSR, 16'h5670 -> 4'b0000.
